decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode stage directly downstream of the fetch stage. Consumes the fetch stage's pc_out/ir_out pair.
- Contains the IF/ID pipeline register, a 32x32 register file with write-through bypass, field extraction and sign-extended immediate generation.
- Detects load-use hazards and drives the stall back to fetch (fetch pc_en = ~stall).
- Registers all results into an ID/EX boundary register consumed by the execute stage.

Parameters:
- XLEN, 32, datapath and instruction width.
- REG_NUM, 32, number of architectural registers; register 0 reads as zero.
- NOP_INSTR, 32'h0000_0000, instruction pattern loaded into IF/ID on reset or flush.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  XLEN  PC of the instruction on ir_in (fetch pc_out).
- ir_in  in  XLEN  fetched instruction (fetch ir_out).
- flush  in  1  branch/jump redirect taken; squash younger instructions.
- wb_en  in  1  register-file write enable from writeback.
- wb_addr  in  5  writeback destination register.
- wb_data  in  XLEN  writeback data.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rt  in  5  destination register of that load.
- stall  out  1  hold fetch PC and IF/ID (combinational).
- id_valid  out  1  ID/EX slot holds a real instruction.
- id_pc  out  XLEN  PC of the decoded instruction.
- id_opcode  out  6  ir[31:26].
- id_funct  out  6  ir[5:0].
- id_rs  out  5  ir[25:21].
- id_rt  out  5  ir[20:16].
- id_rd  out  5  ir[15:11].
- id_shamt  out  5  ir[10:6].
- id_rs_data  out  XLEN  register-file value of rs.
- id_rt_data  out  XLEN  register-file value of rt.
- id_imm  out  XLEN  sign-extended ir[15:0].

Behaviour:
- **Reset:** all cycles with rst=1 at the edge:
  - IF/ID register ← pc 0, ir NOP_INSTR, valid 0.
  - All ID/EX outputs ← 0, including id_valid.
  - All registers r0..r31 ← 0.
  - stall reads 0 while rst=1.
  - Reset mid-operation discards every in-flight instruction; a write on wb_* in the same cycle is dropped.
- **IF/ID capture:** on each edge without stall or flush, capture pc_in/ir_in with valid=1.
- **Latency:** an instruction on ir_in at edge N appears on id_* outputs after edge N+1 (two-register path: IF/ID, then ID/EX).
- **Field decode:** fields are pure slices of the IF/ID instruction. id_imm = {{16{ir[15]}}, ir[15:0]}.
- **Register file:**
  - Write on the clock edge when wb_en=1 and wb_addr≠0. Writes to r0 are ignored; r0 always reads 0.
  - Reads are combinational from the IF/ID rs/rt.
  - Write-through: if wb_en=1 and wb_addr≠0 and wb_addr equals the read address in the same cycle, the read returns wb_data. This value is then registered into id_rs_data/id_rt_data.
- **Load-use hazard:**
  - stall = ex_mem_read & (ex_rt≠0) & IF/ID valid & (ex_rt==IF/ID rs | ex_rt==IF/ID rt) & ~flush.
  - While stall=1: IF/ID holds its contents; ID/EX loads a bubble (id_valid=0, all other id_* ← 0).
  - Stall lasts exactly one cycle per load, because the load leaves EX.
- **Flush:**
  - At the edge with flush=1, IF/ID ← NOP_INSTR/valid 0 and ID/EX ← bubble.
  - Flush has priority over stall; stall is forced to 0 when flush=1.
- **Bubble rule:** an invalid IF/ID entry always produces id_valid=0 with all id_* zeroed. Register reads for a bubble are don't-care internally but are driven as 0.
- **Widths:** no arithmetic is performed beyond the sign extension. Register addresses are 5 bits; REG_NUM must be 32.

Decomposition:
- Shared package (decode_pkg): field bit positions, opcode constants (R-type 6'h00, LW 6'h23, SW 6'h2B, BEQ 6'h04, ADDI 6'h08), NOP_INSTR, and the ID/EX bundle typedef.
- One sub-module: regfile, holding the 32x32 storage, synchronous write, r0 hardwiring and write-through bypass.
- Hazard logic and the pipeline registers stay in decode_stage.

Test Plan:
- **Reset:** rst=1 for 2 cycles with ir_in=32'h2008_0005 → all id_* = 0, id_valid=0, stall=0. After release, that instruction appears 2 edges later with id_imm=5, id_rt=8, id_valid=1.
- **Register read / write-through:**
  - wb_en=1, wb_addr=3, wb_data=32'hDEAD_BEEF in the same cycle IF/ID holds add $1,$3,$0 → id_rs_data=32'hDEAD_BEEF next edge.
  - Writing wb_addr=0 with 32'hFFFF_FFFF leaves r0 reads at 0.
- **Sign extension:** ir=32'h2009_FFFC → id_imm=32'hFFFF_FFFC. ir=32'h2009_7FFF → id_imm=32'h0000_7FFF.
- **Load-use:** ex_mem_read=1, ex_rt=5 while IF/ID holds an instruction with rs=5 → stall=1 for one cycle, IF/ID held, one id_valid=0 bubble. The dependent instruction is then issued with an unchanged id_pc. With ex_rt=0, no stall.
- **Flush priority:** flush=1 together with a load-use condition → stall=0; the next edge yields id_valid=0 and IF/ID valid=0. The instruction fetched from the redirected pc_addr decodes normally 2 edges later.
- **Back-to-back flow:** 4 consecutive instructions with no hazards → id_pc sequence 0,4,8,12 on consecutive cycles with id_valid=1 throughout.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: field positions, opcodes and the ID/EX bundle.
package decode_pkg;

  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int RADDR_W = 5;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   imm;
  } idex_t;

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of fetch, writeback, hazard and ID/EX signals seen by the decode stage.
interface decode_stage_if;
  import decode_pkg::*;

  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] ir_in;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_mem_read;
  logic [4:0]      ex_rt;
  logic            stall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [5:0]      id_opcode;
  logic [5:0]      id_funct;
  logic [4:0]      id_rs;
  logic [4:0]      id_rt;
  logic [4:0]      id_rd;
  logic [4:0]      id_shamt;
  logic [XLEN-1:0] id_rs_data;
  logic [XLEN-1:0] id_rt_data;
  logic [XLEN-1:0] id_imm;

  modport slave (
    input  pc_in, ir_in, flush, wb_en, wb_addr, wb_data, ex_mem_read, ex_rt,
    output stall, id_valid, id_pc, id_opcode, id_funct, id_rs, id_rt, id_rd,
           id_shamt, id_rs_data, id_rt_data, id_imm
  );

  modport master (
    output pc_in, ir_in, flush, wb_en, wb_addr, wb_data, ex_mem_read, ex_rt,
    input  stall, id_valid, id_pc, id_opcode, id_funct, id_rs, id_rt, id_rd,
           id_shamt, id_rs_data, id_rt_data, id_imm
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: synchronous write, r0 hardwired to zero, write-through on read.
module regfile
  import decode_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]    wdata,
  input  logic [RADDR_W-1:0] raddr_a,
  input  logic [RADDR_W-1:0] raddr_b,
  output logic [XLEN-1:0]    rdata_a,
  output logic [XLEN-1:0]    rdata_b
);

  logic [XLEN-1:0] mem [REG_NUM];
  logic            wr_hit;

  assign wr_hit = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle writeback forwards straight to the readers.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != '0) rdata_a = (wr_hit && waddr == raddr_a) ? wdata : mem[raddr_a];
    if (raddr_b != '0) rdata_b = (wr_hit && waddr == raddr_b) ? wdata : mem[raddr_b];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, register-file read, field decode, load-use stall, ID/EX register.
module decode_stage
  import decode_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_ir;
  logic            ifid_valid;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            stall;
  idex_t           idex_nxt;
  idex_t           idex;

  assign rs = ifid_ir[RS_LSB +: 5];
  assign rt = ifid_ir[RT_LSB +: 5];

  regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.wb_en),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  // Flush wins over a load-use hit; reset also masks the stall.
  assign stall = !rst && bus.ex_mem_read && (bus.ex_rt != '0) && ifid_valid &&
                 ((bus.ex_rt == rs) || (bus.ex_rt == rt)) && !bus.flush;
  assign bus.stall = stall;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      ifid_pc    <= '0;
      ifid_ir    <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_pc    <= bus.pc_in;
      ifid_ir    <= bus.ir_in;
      ifid_valid <= 1'b1;
    end
  end

  always_comb begin
    idex_nxt = '0;
    if (ifid_valid && !stall && !bus.flush) begin
      idex_nxt.valid   = 1'b1;
      idex_nxt.pc      = ifid_pc;
      idex_nxt.opcode  = ifid_ir[OPC_LSB +: 6];
      idex_nxt.funct   = ifid_ir[FUNCT_LSB +: 6];
      idex_nxt.rs      = rs;
      idex_nxt.rt      = rt;
      idex_nxt.rd      = ifid_ir[RD_LSB +: 5];
      idex_nxt.shamt   = ifid_ir[SHAMT_LSB +: 5];
      idex_nxt.rs_data = rs_data;
      idex_nxt.rt_data = rt_data;
      idex_nxt.imm     = sign_ext16(ifid_ir[15:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex <= '0;
    else     idex <= idex_nxt;
  end

  assign bus.id_valid   = idex.valid;
  assign bus.id_pc      = idex.pc;
  assign bus.id_opcode  = idex.opcode;
  assign bus.id_funct   = idex.funct;
  assign bus.id_rs      = idex.rs;
  assign bus.id_rt      = idex.rt;
  assign bus.id_rd      = idex.rd;
  assign bus.id_shamt   = idex.shamt;
  assign bus.id_rs_data = idex.rs_data;
  assign bus.id_rt_data = idex.rt_data;
  assign bus.id_imm     = idex.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode, write-through, load-use, flush and streaming.
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ir);
    bus.pc_in = pc;
    bus.ir_in = ir;
  endtask

  initial begin
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rt       = '0;
    drive(32'h0, 32'h2008_0005);

    // reset held for two edges
    step();
    step();
    check("rst_valid", {31'b0, bus.id_valid}, 32'h0);
    check("rst_pc",    bus.id_pc,  32'h0);
    check("rst_imm",   bus.id_imm, 32'h0);
    check("rst_rt",    {27'b0, bus.id_rt}, 32'h0);
    check("rst_stall", {31'b0, bus.stall}, 32'h0);

    rst = 1'b0;
    step();
    check("lat_bubble", {31'b0, bus.id_valid}, 32'h0);

    drive(32'h4, 32'h2009_FFFC);
    step();
    check("addi_valid", {31'b0, bus.id_valid}, 32'h1);
    check("addi_pc",    bus.id_pc, 32'h0);
    check("addi_imm",   bus.id_imm, 32'h0000_0005);
    check("addi_rt",    {27'b0, bus.id_rt}, 32'd8);
    check("addi_opc",   {26'b0, bus.id_opcode}, {26'b0, OPC_ADDI});

    drive(32'h8, 32'h2009_7FFF);
    step();
    check("sext_neg", bus.id_imm, 32'hFFFF_FFFC);
    check("sext_rt",  {27'b0, bus.id_rt}, 32'd9);

    drive(32'hC, 32'h0060_0820);          // add $1,$3,$0
    step();
    check("sext_pos", bus.id_imm, 32'h0000_7FFF);

    // write r3 while IF/ID holds add $1,$3,$0
    drive(32'h10, 32'h0003_1020);         // add $2,$0,$3
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEAD_BEEF;
    step();
    check("wt_rs_data", bus.id_rs_data, 32'hDEAD_BEEF);
    check("wt_rs",      {27'b0, bus.id_rs}, 32'd3);
    check("wt_rd",      {27'b0, bus.id_rd}, 32'd1);
    check("wt_funct",   {26'b0, bus.id_funct}, 32'h20);
    check("wt_pc",      bus.id_pc, 32'hC);

    // attempted write of r0 while IF/ID reads r0 and r3
    drive(32'h14, 32'h0000_0000);
    bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    step();
    check("r0_wt_rs",  bus.id_rs_data, 32'h0);
    check("r3_stored", bus.id_rt_data, 32'hDEAD_BEEF);

    bus.wb_en = 1'b0;
    drive(32'h18, 32'h00A0_2020);         // add $4,$5,$0
    step();
    check("r0_read_rs", bus.id_rs_data, 32'h0);
    check("r0_read_rt", bus.id_rt_data, 32'h0);
    check("nop_pc",     bus.id_pc, 32'h14);

    // load-use on rs=5
    drive(32'h1C, 32'h2009_0001);
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5;
    #1;
    check("lu_stall", {31'b0, bus.stall}, 32'h1);
    step();
    check("lu_bubble_v",  {31'b0, bus.id_valid}, 32'h0);
    check("lu_bubble_pc", bus.id_pc, 32'h0);
    bus.ex_mem_read = 1'b0;
    #1;
    check("lu_release", {31'b0, bus.stall}, 32'h0);
    step();
    check("lu_issue_v",  {31'b0, bus.id_valid}, 32'h1);
    check("lu_issue_pc", bus.id_pc, 32'h18);
    check("lu_issue_rs", {27'b0, bus.id_rs}, 32'd5);

    // load to r0 never stalls
    drive(32'h20, 32'h00A0_2020);
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0;
    #1;
    check("rt0_nostall", {31'b0, bus.stall}, 32'h0);
    step();
    check("rt0_pc",  bus.id_pc, 32'h1C);
    check("rt0_imm", bus.id_imm, 32'h1);

    // flush together with a load-use hit on IF/ID rs=5
    drive(32'h24, 32'h2008_0007);
    bus.ex_rt = 5'd5; bus.flush = 1'b1;
    #1;
    check("fl_stall", {31'b0, bus.stall}, 32'h0);
    step();
    check("fl_bubble", {31'b0, bus.id_valid}, 32'h0);
    bus.flush = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rt = '0;
    drive(32'h80, 32'h2008_0042);
    step();
    check("fl_ifid_inv", {31'b0, bus.id_valid}, 32'h0);
    drive(32'h84, 32'h2008_0043);
    step();
    check("redir_v",   {31'b0, bus.id_valid}, 32'h1);
    check("redir_pc",  bus.id_pc, 32'h80);
    check("redir_imm", bus.id_imm, 32'h42);

    // back-to-back stream
    for (int i = 0; i < 6; i++) begin
      drive(32'(4 * i), 32'h2001_0000 | 32'(i));
      step();
      if (i >= 1 && i <= 4) begin
        check("b2b_pc", bus.id_pc, 32'(4 * (i - 1)));
        check("b2b_v",  {31'b0, bus.id_valid}, 32'h1);
      end
    end

    // reset mid-stream drops the concurrent write
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h1234_5678;
    rst = 1'b1;
    step();
    check("mrst_valid", {31'b0, bus.id_valid}, 32'h0);
    rst = 1'b0; bus.wb_en = 1'b0;
    drive(32'h40, 32'h00E0_0000);         // reads r7
    step();
    step();
    check("mrst_v",     {31'b0, bus.id_valid}, 32'h1);
    check("mrst_r7",    bus.id_rs_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
